// File: rtl/serial_add_sequencer_if.sv
// Request/response bundle for serial_add_sequencer: operand handshake in,
// result handshake out, plus the busy indicator.
interface serial_add_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_add_term1;
    logic [WIDTH-1:0] i_add_term2;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH:0]   o_result;
    logic             o_busy;

    // Requester/consumer side
    modport master (
        output i_valid, i_add_term1, i_add_term2, i_ready,
        input  o_ready, o_valid, o_result, o_busy
    );

    // Adder side
    modport slave (
        input  i_valid, i_add_term1, i_add_term2, i_ready,
        output o_ready, o_valid, o_result, o_busy
    );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial unsigned adder: one full_adder cell is reused for WIDTH cycles,
// LSB first, with the carry held in a register between cycles.

// Single-bit full adder cell reused by the sequencer.
module full_adder (
    input  logic i_bit1,
    input  logic i_bit2,
    input  logic i_carry,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_bit1 ^ i_bit2 ^ i_carry;
    assign o_carry = (i_bit1 & i_bit2) | (i_carry & (i_bit1 ^ i_bit2));
endmodule

module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    serial_add_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   result_q, result_d;
    logic [WIDTH-1:0] low_shift;
    logic             fa_sum;
    logic             fa_carry;

    // The only arithmetic cell on the sum path: always fed by the operand LSBs.
    full_adder u_full_adder (
        .i_bit1  (a_q[0]),
        .i_bit2  (b_q[0]),
        .i_carry (carry_q),
        .o_sum   (fa_sum),
        .o_carry (fa_carry)
    );

    // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        // New sum bit enters at the top of the sum field, older bits move down.
        low_shift            = result_q[WIDTH-1:0] >> 1;
        low_shift[WIDTH-1]   = fa_sum;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    a_d      = bus.i_add_term1;
                    b_d      = bus.i_add_term2;
                    carry_d  = 1'b0;
                    cnt_d    = '0;
                    result_d = '0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                carry_d  = fa_carry;
                cnt_d    = cnt_q + CNT_W'(1);
                result_d = {result_q[WIDTH], low_shift};
                if (cnt_q == LAST_BIT) begin
                    result_d[WIDTH] = fa_carry;
                    state_d         = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and visible result: cleared by reset, dropping any in-flight add.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Operand shift registers: always reloaded on accept, so no reset needed.
    always_ff @(posedge i_clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign bus.o_ready  = (state_q == ST_IDLE);
    assign bus.o_busy   = (state_q == ST_BUSY);
    assign bus.o_valid  = (state_q == ST_DONE);
    assign bus.o_result = result_q;
endmodule
